// File: rtl/regfile.sv
`timescale 1ns/1ps
// regfile
// -------
// Integer register file for the single-cycle RV32I core. Provides two
// asynchronous operand read ports for the decode stage, one synchronous write
// port committed at the rising clock edge, and an independent debug read port
// for the bench and FPGA wrapper. Register x0 is hardwired to zero and has no
// storage behind it.
//
// Ports:
//   clk       core clock, register updates on the rising edge
//   rst_n     asynchronous active-low reset, clears x1..x(NUM_REGS-1)
//   rs1_addr  read port 1 index
//   rs2_addr  read port 2 index
//   rd_addr   write port index
//   rd_data   write data
//   rd_wren   write enable
//   dbg_addr  debug read index
//   rs1_data  contents of rs1_addr (brcomp, ALU operand A)
//   rs2_data  contents of rs2_addr (brcomp, ALU operand B mux, store data)
//   dbg_data  contents of dbg_addr
module regfile #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_wren,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data
);

  // Storage starts at index 1: x0 is a constant, not a flop.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  logic write_hit;

  // A write only lands when enabled and aimed at a real register; writes to
  // x0 are silently dropped here so the array never sees index 0.
  assign write_hit = rd_wren && (rd_addr != '0);

  // Register array. Reset clears every stored register asynchronously and
  // takes priority over any write sampled at the same edge, so a write that
  // coincides with reset is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Shared read decode for all three ports. Index 0 returns zero rather than
  // touching the array. There is deliberately no forwarding from rd_data:
  // rd_data is derived combinationally from rs1_data/rs2_data in the
  // single-cycle datapath, so a bypass here would close a combinational loop.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = '0;
    if (addr != '0) begin
      value = regs[addr];
    end
    return value;
  endfunction

  // Three independent combinational read ports; any mix of equal addresses
  // (including equal to rd_addr) simply reads the current contents.
  always_comb begin
    rs1_data = read_reg(rs1_addr);
    rs2_data = read_reg(rs2_addr);
    dbg_data = read_reg(dbg_addr);
  end

endmodule

// File: tb/tb_regfile.sv
`timescale 1ns/1ps
// tb_regfile
// ----------
// Self-checking bench for regfile. A plain array model holds the architectural
// register values; every read port is compared against it. Directed scenarios
// cover reset, basic write/read, x0 protection, no-bypass timing and write
// enable gating, followed by a long randomized run with random reset pulses.
module tb_regfile;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_wren;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] dbg_data;

  int testsRun;
  int failCount;

  // Architectural view of the register file: 32 words, entry 0 never written.
  logic [DATA_W-1:0] model [NUM_REGS];

  regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_wren (rd_wren),
    .dbg_addr(dbg_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .dbg_data(dbg_data)
  );

  // 20 ns clock; inputs change on the falling edge, outputs checked shortly after.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] addr);
    return (addr == 0) ? '0 : model[addr];
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endfunction

  // Architectural write rule applied at a rising edge.
  function automatic void modelWrite();
    if (rst_n && rd_wren && rd_addr != 0) model[rd_addr] = rd_data;
  endfunction

  task automatic applyStimulus(input logic wren, input logic [ADDR_W-1:0] rd,
                               input logic [DATA_W-1:0] data,
                               input logic [ADDR_W-1:0] a1,
                               input logic [ADDR_W-1:0] a2,
                               input logic [ADDR_W-1:0] ad);
    rd_wren  = wren;
    rd_addr  = rd;
    rd_data  = data;
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = ad;
  endtask

  // One rising edge, model updated with the same inputs the DUT sampled,
  // then back to the falling edge for the next stimulus.
  task automatic tick();
    @(posedge clk);
    modelWrite();
    @(negedge clk);
  endtask

  task automatic checkPorts(input string tag);
    checkOutput({tag, "_rs1"}, rs1_data, modelRead(rs1_addr));
    checkOutput({tag, "_rs2"}, rs2_data, modelRead(rs2_addr));
    checkOutput({tag, "_dbg"}, dbg_data, modelRead(dbg_addr));
  endtask

  // Walk every index through all three ports within half a clock period.
  task automatic checkSweep(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      rs1_addr = ADDR_W'(i);
      rs2_addr = ADDR_W'(NUM_REGS - 1 - i);
      dbg_addr = ADDR_W'((i + 5) % NUM_REGS);
      #0.1;
      checkPorts(tag);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    modelClear();
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);

    // Power-on reset: everything reads zero.
    #1;
    checkSweep("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill some registers, then reset between edges.
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, ADDR_W'(i * 4 + 1), $urandom, '0, '0, '0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 5'd5, 5'd9, 5'd29);
    #1;
    checkPorts("prefill");
    #2;
    rst_n = 1'b0;
    modelClear();
    #0.1;
    checkSweep("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write/read and swap.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, '0, '0, '0);
    tick();
    applyStimulus(1'b1, 5'd31, 32'h8000_0000, '0, '0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 5'd5, 5'd31, 5'd5);
    #1;
    checkOutput("wr_x5_rs1", rs1_data, 32'hDEAD_BEEF);
    checkOutput("wr_x31_rs2", rs2_data, 32'h8000_0000);
    rs1_addr = 5'd31;
    rs2_addr = 5'd5;
    #1;
    checkOutput("swap_rs1", rs1_data, 32'h8000_0000);
    checkOutput("swap_rs2", rs2_data, 32'hDEAD_BEEF);
    checkOutput("brcomp_signed_less",
                {31'b0, $signed(rs1_data) < $signed(rs2_data)}, 32'd1);
    @(negedge clk);

    // x0 protection.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, '0, '0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    #1;
    checkOutput("x0_rs1", rs1_data, 32'h0);
    checkOutput("x0_rs2", rs2_data, 32'h0);
    checkOutput("x0_dbg", dbg_data, 32'h0);
    checkSweep("x0_others");
    @(negedge clk);

    // No bypass: old value before the edge, new value after it.
    applyStimulus(1'b1, 5'd7, 32'h1111_1111, '0, '0, '0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 5'd7);
    #1;
    checkOutput("nobyp_before_rs1", rs1_data, 32'h1111_1111);
    checkOutput("nobyp_before_dbg", dbg_data, 32'h1111_1111);
    @(posedge clk);
    modelWrite();
    #1;
    checkOutput("nobyp_after_rs1", rs1_data, 32'h2222_2222);
    checkOutput("nobyp_after_rs2", rs2_data, 32'h2222_2222);
    @(negedge clk);

    // Write-enable gating on x9.
    applyStimulus(1'b1, 5'd9, 32'hA5A5_5A5A, '0, '0, '0);
    tick();
    applyStimulus(1'b0, 5'd9, 32'h1234_5678, 5'd9, 5'd9, 5'd9);
    for (int e = 0; e < 3; e++) tick();
    #1;
    checkOutput("wren_gate_rs1", rs1_data, 32'hA5A5_5A5A);
    checkOutput("wren_gate_dbg", dbg_data, 32'hA5A5_5A5A);
    @(negedge clk);

    // Randomized regression with occasional reset pulses.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [ADDR_W-1:0] rd;
      rd = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      applyStimulus(1'($urandom_range(0, 1)), rd, $urandom,
                    ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom_range(0, 31)),
                    ADDR_W'($urandom_range(0, 31)));
      #1;
      checkPorts("rand");
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        modelClear();
        #0.1;
        checkPorts("rand_rst");
        // The write pending at this edge is lost while reset is held.
        @(posedge clk);
        #1;
        checkPorts("rand_rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
